// File: rtl/uart_tx_frame_arbiter_pkg.sv
// uart_tx_frame_arbiter_pkg
//   Shared definitions for the UART TX frame arbiter: FSM state encoding,
//   parameter defaults and a saturating counter helper.
package uart_tx_frame_arbiter_pkg;

  // Frame FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Default frame length: one 32-bit found-nonce word.
  localparam int FRAME_BYTES_DEF   = 4;
  // Default mid-frame stall limit before a frame is dropped.
  localparam int STALL_TIMEOUT_DEF = 1000000;
  // Default stall counter width; must cover STALL_TIMEOUT.
  localparam int CNT_W_DEF         = 20;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_arb2.sv
// uart_tx_frame_arbiter_rr_arb2
//   Two-requester round-robin picker (rr_arb2). The winner is combinational
//   from req and the registered last owner; the last owner register is
//   updated only when the caller commits a grant.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   req[1:0]     : request per source (bit 0 = source 0)
//   update       : commit the current winner as the new last owner
//   winner[1:0]  : one-hot winner, 00 when nobody requests
module uart_tx_frame_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] winner
);

  // 0 = source 0 owned last, 1 = source 1 owned last.
  logic last_owner_q;
  logic last_owner_d;

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      // On a tie the source that did not own last goes first.
      2'b11:   winner = last_owner_q ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase

    last_owner_d = last_owner_q;
    if (update && (winner != 2'b00)) begin
      last_owner_d = winner[1];
    end
  end

  // Reset to "source 1 owned last" so source 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter
//   Shares one UART transmitter between two byte-stream frame sources.
//   Whole frames of FRAME_BYTES bytes are granted round-robin; a granted
//   source that stalls mid-frame for STALL_TIMEOUT serializer-idle cycles
//   loses its frame so a dead link cannot lock out the other source.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   s0_data/valid/ready : local result source (source 0)
//   s1_data/valid/ready : forwarded slave source (source 1)
//   tx_data, tx_start   : byte and one-cycle start pulse to the serializer
//   tx_busy             : serializer busy, rises the cycle after tx_start
//   grant[1:0]          : one-hot current owner, 00 when idle
//   frame_abort         : one-cycle pulse when a frame is timed out
//   abort_count[7:0]    : saturating count of aborted frames
//   state_dbg[1:0]      : current FSM state (state_e encoding)
//
// Handshake: a source byte moves when sN_valid and sN_ready are both high at
// a rising clk edge. sN_valid doubles as the frame request while idle. Ready
// is combinational, only for the owner, only in SEND with tx_busy low, and
// never depends on valid. A source must hold data stable until accepted.
module uart_tx_frame_arbiter
  import uart_tx_frame_arbiter_pkg::*;
#(
  parameter int FRAME_BYTES   = FRAME_BYTES_DEF,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       frame_abort,
  output logic [7:0] abort_count,
  output logic [1:0] state_dbg
);

  localparam logic [7:0]       FRAME_LEN  = 8'(FRAME_BYTES);
  // Abort fires on the cycle that would bring the count to STALL_TIMEOUT.
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

  state_e           state_q,       state_d;
  logic [1:0]       grant_q,       grant_d;
  logic [7:0]       tx_data_q,     tx_data_d;
  logic             tx_start_q,    tx_start_d;
  logic             frame_abort_q, frame_abort_d;
  logic [7:0]       abort_count_q, abort_count_d;
  logic [7:0]       byte_cnt_q,    byte_cnt_d;
  logic [CNT_W-1:0] stall_q,       stall_d;

  logic [1:0] arb_winner;
  logic       arb_take;
  logic       send_ready;
  logic       owner_valid;
  logic [7:0] owner_data;
  logic       accept;

  uart_tx_frame_arbiter_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    ({s1_valid, s0_valid}),
    .update (arb_take),
    .winner (arb_winner)
  );

  // Ready gating on tx_busy also holds off the first byte of a back-to-back
  // frame until the previous frame's last byte has finished shifting.
  assign send_ready  = (state_q == ST_SEND) && !tx_busy;
  assign s0_ready    = send_ready && grant_q[0];
  assign s1_ready    = send_ready && grant_q[1];
  assign owner_valid = grant_q[1] ? s1_valid : s0_valid;
  assign owner_data  = grant_q[1] ? s1_data  : s0_data;
  assign accept      = send_ready && owner_valid;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    frame_abort_d = 1'b0;
    abort_count_d = abort_count_q;
    byte_cnt_d    = byte_cnt_q;
    stall_d       = stall_q;
    arb_take      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // No byte moves in the grant cycle; ready is low outside SEND.
        if (arb_winner != 2'b00) begin
          grant_d    = arb_winner;
          arb_take   = 1'b1;
          byte_cnt_d = 8'd0;
          stall_d    = '0;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (accept) begin
          tx_data_d  = owner_data;
          tx_start_d = 1'b1;
          byte_cnt_d = byte_cnt_q + 8'd1;
          stall_d    = '0;
          state_d    = ST_WAIT;
        end else if (!owner_valid && !tx_busy) begin
          // Only serializer-idle cycles count as a source stall.
          if (stall_q == STALL_LAST) begin
            frame_abort_d = 1'b1;
            abort_count_d = sat_inc8(abort_count_q);
            grant_d       = 2'b00;
            stall_d       = '0;
            state_d       = ST_IDLE;
          end else begin
            stall_d = stall_q + CNT_W'(1);
          end
        end
      end

      ST_WAIT: begin
        // One dead cycle so tx_busy is visible before ready can rise again.
        if (byte_cnt_q == FRAME_LEN) begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= 2'b00;
      tx_data_q     <= 8'd0;
      tx_start_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      abort_count_q <= 8'd0;
      byte_cnt_q    <= 8'd0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      frame_abort_q <= frame_abort_d;
      abort_count_q <= abort_count_d;
      byte_cnt_q    <= byte_cnt_d;
      stall_q       <= stall_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign frame_abort = frame_abort_q;
  assign abort_count = abort_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter
//   Scenario bench for uart_tx_frame_arbiter. Sources are queue-fed drivers,
//   the serializer is a fixed-length busy model, and expected output streams
//   come from a frame-level round-robin model.
module tb_uart_tx_frame_arbiter;
  import uart_tx_frame_arbiter_pkg::*;

  localparam int FB   = 4;
  localparam int TO   = 16;
  localparam int BUSY = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [1:0] grant;
  logic       frame_abort;
  logic [7:0] abort_count;
  logic [1:0] state_dbg;

  uart_tx_frame_arbiter #(
    .FRAME_BYTES   (FB),
    .STALL_TIMEOUT (TO),
    .CNT_W         (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s0_data     (s0_data),
    .s0_valid    (s0_valid),
    .s0_ready    (s0_ready),
    .s1_data     (s1_data),
    .s1_valid    (s1_valid),
    .s1_ready    (s1_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .frame_abort (frame_abort),
    .abort_count (abort_count),
    .state_dbg   (state_dbg)
  );

  // ---------------- serializer model ----------------
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= BUSY;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  logic [7:0] s0_src[$];
  logic [7:0] s1_src[$];
  bit         s0_take = 1'b0, s1_take = 1'b0;

  logic [7:0] got_data[$];
  logic [1:0] got_src[$];
  int         start_cyc[$];
  int         abort_cyc[$];
  logic [1:0] grant_seq[$];
  logic [1:0] prev_grant = 2'b00;

  logic [7:0] frm0[$];
  logic [7:0] frm1[$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_src[$];
  logic [1:0] exp_grants[$];

  // Monitor then source drivers, once per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        got_data.push_back(tx_data);
        got_src.push_back(grant);
        start_cyc.push_back(cyc);
      end
      if (frame_abort) abort_cyc.push_back(cyc);
      if (grant != 2'b00 && grant != prev_grant) grant_seq.push_back(grant);
      prev_grant = grant;
      if ((s0_ready && s1_ready) || grant == 2'b11 ||
          (s0_ready && !grant[0]) || (s1_ready && !grant[1]))
        viol++;

      if (s0_take) void'(s0_src.pop_front());
      if (s1_take) void'(s1_src.pop_front());
      s0_valid = (s0_src.size() > 0);
      s0_data  = s0_valid ? s0_src[0] : 8'h00;
      s1_valid = (s1_src.size() > 0);
      s1_data  = s1_valid ? s1_src[0] : 8'h00;
      s0_take  = s0_valid && s0_ready && !reset;
      s1_take  = s1_valid && s1_ready && !reset;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    s0_src.delete(); s1_src.delete();
    s0_take = 1'b0; s1_take = 1'b0;
    force_busy = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
    got_data.delete(); got_src.delete(); start_cyc.delete();
    abort_cyc.delete(); grant_seq.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_data.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    if (got_data.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_aborts(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (abort_cyc.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    if (abort_cyc.size() >= n) ok = 1'b1;
  endtask

  task automatic fill_random(input int n0, input int n1);
    frm0.delete(); frm1.delete();
    for (int i = 0; i < n0 * FB; i++) frm0.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < n1 * FB; i++) frm1.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame-level reference: whole frames, tie goes to the source that did not
  // own last; after reset source 1 counts as the last owner.
  task automatic model_rr(input int n0, input int n1);
    int i0 = 0;
    int i1 = 0;
    int pick;
    int last = 1;
    exp_q.delete(); exp_src.delete(); exp_grants.delete();
    while (i0 < n0 || i1 < n1) begin
      if (i0 < n0 && i1 < n1) pick = (last == 1) ? 0 : 1;
      else pick = (i0 < n0) ? 0 : 1;
      for (int b = 0; b < FB; b++) begin
        if (pick == 0) begin
          exp_q.push_back(frm0[i0 * FB + b]); exp_src.push_back(2'b01);
        end else begin
          exp_q.push_back(frm1[i1 * FB + b]); exp_src.push_back(2'b10);
        end
      end
      exp_grants.push_back(pick == 0 ? 2'b01 : 2'b10);
      if (pick == 0) i0++; else i1++;
      last = pick;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    bit ok;
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    fill_random(1, 1);
    foreach (frm0[i]) s0_src.push_back(frm0[i]);
    foreach (frm1[i]) s1_src.push_back(frm1[i]);
    repeat (3) begin @(posedge clk); #2; end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got=%b want=00", grant); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got=%b want=0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got=%h want=00", tx_data); end
    total++; if (s0_ready !== 1'b0) begin bad++; $display("FAIL reset_s0_ready: got=%b want=0", s0_ready); end
    total++; if (s1_ready !== 1'b0) begin bad++; $display("FAIL reset_s1_ready: got=%b want=0", s1_ready); end
    total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL reset_abort: got=%b want=0", frame_abort); end
    total++; if (abort_count !== 8'd0) begin bad++; $display("FAIL reset_abort_count: got=%0d want=0", abort_count); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state: got=%0d want=%0d", state_dbg, ST_IDLE); end
    got_data.delete(); got_src.delete(); start_cyc.delete(); grant_seq.delete();
    reset = 1'b0;
    @(posedge clk); #2;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL reset_first_grant: got=%b want=01", grant); end
    model_rr(1, 1);
    wait_bytes(exp_q.size(), 300, ok);
    total++; if (!ok) begin bad++; $display("FAIL reset_drain_timeout: got=%0d want=%0d bytes", got_data.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_src[i] !== exp_src[i]) begin
        bad++;
        $display("FAIL reset_stream[%0d]: got=%h/%b want=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 8'hxx,
                 (i < got_src.size()) ? got_src[i] : 2'bxx, exp_q[i], exp_src[i]);
      end
    end
  endtask

  task automatic test_single_frame;
    bit ok;
    logic [7:0] want [4];
    want[0] = 8'hDE; want[1] = 8'hAD; want[2] = 8'hBE; want[3] = 8'hEF;
    do_reset(2);
    for (int i = 0; i < 4; i++) s0_src.push_back(want[i]);
    wait_bytes(4, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got=%0d want=4 bytes", got_data.size()); end
    repeat (4) begin @(posedge clk); #2; end
    total++; if (got_data.size() !== 4) begin bad++; $display("FAIL single_count: got=%0d want=4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== want[i] || got_src[i] !== 2'b01) begin
        bad++;
        $display("FAIL single_byte[%0d]: got=%h want=%h", i,
                 (i < got_data.size()) ? got_data[i] : 8'hxx, want[i]);
      end
    end
    for (int i = 1; i < start_cyc.size(); i++) begin
      total++;
      if (start_cyc[i] - start_cyc[i-1] > BUSY + 2) begin
        bad++;
        $display("FAIL single_rate[%0d]: got=%0d want<=%0d cycles", i, start_cyc[i] - start_cyc[i-1], BUSY + 2);
      end
    end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_grant_end: got=%b want=00", grant); end
  endtask

  task automatic test_contention;
    bit ok;
    do_reset(2);
    fill_random(2, 1);
    for (int i = 0; i < FB; i++) begin
      frm0[i] = 8'h11 + 8'(i);
      frm1[i] = 8'h21 + 8'(i);
    end
    foreach (frm0[i]) s0_src.push_back(frm0[i]);
    foreach (frm1[i]) s1_src.push_back(frm1[i]);
    model_rr(2, 1);
    wait_bytes(exp_q.size(), 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL contention_timeout: got=%0d want=%0d bytes", got_data.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_src[i] !== exp_src[i]) begin
        bad++;
        $display("FAIL contention_stream[%0d]: got=%h/%b want=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 8'hxx,
                 (i < got_src.size()) ? got_src[i] : 2'bxx, exp_q[i], exp_src[i]);
      end
    end
    total++;
    if (grant_seq.size() !== exp_grants.size()) begin
      bad++; $display("FAIL contention_grants_len: got=%0d want=%0d", grant_seq.size(), exp_grants.size());
    end else begin
      foreach (exp_grants[i]) if (grant_seq[i] !== exp_grants[i]) begin
        bad++; $display("FAIL contention_grant[%0d]: got=%b want=%b", i, grant_seq[i], exp_grants[i]); break;
      end
    end
  endtask

  task automatic test_random_frames;
    bit ok;
    int n0, n1;
    for (int it = 0; it < 4; it++) begin
      do_reset(2);
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(1, 3);
      fill_random(n0, n1);
      foreach (frm0[i]) s0_src.push_back(frm0[i]);
      foreach (frm1[i]) s1_src.push_back(frm1[i]);
      model_rr(n0, n1);
      wait_bytes(exp_q.size(), 800, ok);
      total++; if (!ok) begin bad++; $display("FAIL random_timeout[%0d]: got=%0d want=%0d bytes", it, got_data.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        total++;
        if (i >= got_data.size() || got_data[i] !== exp_q[i] || got_src[i] !== exp_src[i]) begin
          bad++;
          $display("FAIL random_stream[%0d][%0d]: got=%h/%b want=%h/%b", it, i,
                   (i < got_data.size()) ? got_data[i] : 8'hxx,
                   (i < got_src.size()) ? got_src[i] : 2'bxx, exp_q[i], exp_src[i]);
        end
      end
    end
  endtask

  task automatic test_stall_timeout;
    bit ok;
    int i0;
    do_reset(2);
    fill_random(1, 1);
    s1_src.push_back(frm1[0]);
    s1_src.push_back(frm1[1]);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (grant == 2'b10) begin ok = 1'b1; break; end
      @(posedge clk); #2;
    end
    total++; if (!ok) begin bad++; $display("FAIL stall_grant_s1: got=%b want=10", grant); end
    foreach (frm0[i]) s0_src.push_back(frm0[i]);
    wait_bytes(2, 100, ok);
    wait_aborts(1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_no_abort: got=0 want=1 pulses"); end
    total++;
    if (abort_cyc.size() < 1 || start_cyc.size() < 2 ||
        abort_cyc[0] !== start_cyc[1] + BUSY + TO + 1) begin
      bad++;
      $display("FAIL stall_abort_time: got=%0d want=%0d",
               (abort_cyc.size() > 0) ? abort_cyc[0] : -1,
               (start_cyc.size() > 1) ? start_cyc[1] + BUSY + TO + 1 : -1);
    end
    total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL stall_pulse_width: got=%b want=0", frame_abort); end
    total++; if (abort_count !== 8'd1) begin bad++; $display("FAIL stall_abort_count: got=%0d want=1", abort_count); end
    wait_bytes(2 + FB, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_s0_timeout: got=%0d want=%0d bytes", got_data.size(), 2 + FB); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== frm1[i] || got_src[i] !== 2'b10) begin
        bad++; $display("FAIL stall_s1_byte[%0d]: got=%h want=%h", i, (i < got_data.size()) ? got_data[i] : 8'hxx, frm1[i]);
      end
    end
    for (int i = 0; i < FB; i++) begin
      i0 = i + 2;
      total++;
      if (i0 >= got_data.size() || got_data[i0] !== frm0[i] || got_src[i0] !== 2'b01) begin
        bad++; $display("FAIL stall_s0_byte[%0d]: got=%h want=%h", i, (i0 < got_data.size()) ? got_data[i0] : 8'hxx, frm0[i]);
      end
    end
    total++;
    if (grant_seq.size() !== 2 || grant_seq[0] !== 2'b10 || grant_seq[1] !== 2'b01) begin
      bad++; $display("FAIL stall_grant_seq: got=%0d entries want=10,01", grant_seq.size());
    end
    total++; if (abort_cyc.size() !== 1) begin bad++; $display("FAIL stall_abort_pulses: got=%0d want=1", abort_cyc.size()); end
  endtask

  task automatic test_mid_frame_reset;
    bit ok;
    do_reset(2);
    fill_random(1, 1);
    foreach (frm0[i]) s0_src.push_back(frm0[i]);
    wait_bytes(2, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_start: got=%0d want=2 bytes", got_data.size()); end
    reset = 1'b1;
    s0_src.delete();
    @(posedge clk); #2;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL midrst_tx_start: got=%b want=0", tx_start); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL midrst_grant: got=%b want=00", grant); end
    @(posedge clk); #2;
    total++; if (got_data.size() !== 2) begin bad++; $display("FAIL midrst_no_more_bytes: got=%0d want=2", got_data.size()); end
    reset = 1'b0;
    foreach (frm1[i]) s1_src.push_back(frm1[i]);
    @(posedge clk); #2;
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL midrst_s1_grant: got=%b want=10", grant); end
    wait_bytes(2 + FB, 200, ok);
    for (int i = 0; i < FB; i++) begin
      total++;
      if (i + 2 >= got_data.size() || got_data[i+2] !== frm1[i] || got_src[i+2] !== 2'b10) begin
        bad++; $display("FAIL midrst_s1_byte[%0d]: got=%h want=%h", i, (i + 2 < got_data.size()) ? got_data[i+2] : 8'hxx, frm1[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset(2);
    fill_random(1, 0);
    s0_src.push_back(frm0[0]);
    wait_bytes(1, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_first_byte: got=%0d want=1 bytes", got_data.size()); end
    force_busy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      total++; if (s0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got=%b want=0", i, s0_ready); end
      total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL bp_tx_start[%0d]: got=%b want=0", i, tx_start); end
      total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL bp_abort[%0d]: got=%b want=0", i, frame_abort); end
    end
    for (int i = 1; i < FB; i++) s0_src.push_back(frm0[i]);
    force_busy = 1'b0;
    wait_bytes(FB, 200, ok);
    repeat (3) begin @(posedge clk); #2; end
    for (int i = 0; i < FB; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== frm0[i]) begin
        bad++; $display("FAIL bp_byte[%0d]: got=%h want=%h", i, (i < got_data.size()) ? got_data[i] : 8'hxx, frm0[i]);
      end
    end
    total++; if (abort_count !== 8'd0) begin bad++; $display("FAIL bp_abort_count: got=%0d want=0", abort_count); end
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL bp_grant_end: got=%b want=00", grant); end
  endtask

  task automatic test_abort_saturation;
    bit ok;
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      s1_src.push_back(8'($urandom_range(0, 255)));
      wait_aborts(i + 1, 100, ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL sat_abort_timeout[%0d]: got=%0d want=%0d aborts", i, abort_cyc.size(), i + 1);
        break;
      end
      if (i == 0 || i == 254 || i == 255) begin
        total++;
        if (abort_count !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
          bad++; $display("FAIL sat_count[%0d]: got=%0d want=%0d", i, abort_count, (i + 1 > 255) ? 255 : i + 1);
        end
      end
    end
  endtask

  task automatic test_invariants;
    total++;
    if (viol !== 0) begin bad++; $display("FAIL invariants: got=%0d want=0 violating cycles", viol); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_contention();
    test_random_frames();
    test_stall_timeout();
    test_mid_frame_reset();
    test_backpressure();
    test_abort_saturation();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
